// File: rtl/systolic_seq.sv
// systolic_seq: clear/compute/drain sequencer for an N x N systolic MAC array
module systolic_seq #(
  parameter int N      = 4,
  parameter int K_MAX  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          pu_clr,
  output logic [N*N-1:0]                pu_en,
  output logic                          a_rd_en,
  output logic [ADDR_W-1:0]             a_rd_addr,
  output logic                          b_rd_en,
  output logic [ADDR_W-1:0]             b_rd_addr,
  output logic [((N>1)?$clog2(N):1)-1:0] res_sel,
  output logic                          res_valid,
  input  logic                          res_ready
);
  localparam int KL_W = $clog2(K_MAX+1);
  localparam int TW   = $clog2(K_MAX+2*N-1);
  localparam int SW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_nxt_state;
  logic [TW-1:0]    r_t, w_nxt_t, w_t_last;
  logic [KL_W-1:0]  r_klen, w_nxt_klen, w_klen_c;
  logic [SW-1:0]    r_sel, w_nxt_sel;
  logic [N*N-1:0]   w_en;
  logic             w_rd;

  // next-state, phase counter and drain row; abort overrides everything outside IDLE
  always_comb begin
    w_klen_c    = (k_len > KL_W'(K_MAX)) ? KL_W'(K_MAX) : k_len;
    w_t_last    = TW'(r_klen) + TW'(2*N-2);
    w_nxt_state = r_state;
    w_nxt_t     = r_t;
    w_nxt_sel   = r_sel;
    w_nxt_klen  = r_klen;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_nxt_klen  = w_klen_c;
        w_nxt_state = (w_klen_c == '0) ? S_DONE : S_CLEAR;
        w_nxt_t     = '0;
        w_nxt_sel   = '0;
      end
      S_CLEAR: begin
        w_nxt_state = S_COMPUTE;
        w_nxt_t     = '0;
      end
      S_COMPUTE: begin
        w_nxt_state = (r_t == w_t_last) ? S_DRAIN : S_COMPUTE;
        w_nxt_t     = (r_t == w_t_last) ? r_t : r_t + TW'(1);
        w_nxt_sel   = '0;
      end
      S_DRAIN: if (res_ready) begin
        w_nxt_state = (r_sel == SW'(N-1)) ? S_DONE : S_DRAIN;
        w_nxt_sel   = (r_sel == SW'(N-1)) ? r_sel : r_sel + SW'(1);
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_nxt_state = S_IDLE;
  end

  // diagonal skew: PU(i,j) sees operand k at phase k+1+i+j
  always_comb begin
    w_en = '0;
    w_rd = (w_nxt_state == S_COMPUTE) && (w_nxt_t < TW'(w_nxt_klen));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w_en[i*N+j] = (w_nxt_state == S_COMPUTE) && (w_nxt_t >= TW'(1+i+j)) &&
                      (w_nxt_t <= TW'(w_nxt_klen) + TW'(i+j));
  end

  // state and all outputs registered from the next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_t       <= '0;
      r_sel     <= '0;
      r_klen    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pu_clr    <= 1'b0;
      pu_en     <= '0;
      a_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      b_rd_en   <= 1'b0;
      b_rd_addr <= '0;
      res_sel   <= '0;
      res_valid <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_t       <= w_nxt_t;
      r_sel     <= w_nxt_sel;
      r_klen    <= w_nxt_klen;
      busy      <= w_nxt_state != S_IDLE;
      done      <= w_nxt_state == S_DONE;
      pu_clr    <= w_nxt_state == S_CLEAR;
      pu_en     <= w_en;
      a_rd_en   <= w_rd;
      a_rd_addr <= w_rd ? ADDR_W'(w_nxt_t) : '0;
      b_rd_en   <= w_rd;
      b_rd_addr <= w_rd ? ADDR_W'(w_nxt_t) : '0;
      res_sel   <= (w_nxt_state == S_DRAIN) ? w_nxt_sel : '0;
      res_valid <= w_nxt_state == S_DRAIN;
    end
  end
endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: cycle-exact scoreboard bench for systolic_seq
module tb_systolic_seq;
  localparam int N = 4, K_MAX = 256, AW = 8, KW = 9, VW = 40;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic busy, done, pu_clr, a_rd_en, b_rd_en, res_valid;
  logic [N*N-1:0] pu_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [1:0] res_sel;
  logic [VW-1:0] obs;
  logic [VW-1:0] q[$];
  int tests = 0, fails = 0;

  systolic_seq #(.N(N), .K_MAX(K_MAX), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .pu_clr(pu_clr), .pu_en(pu_en),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .res_sel(res_sel), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, pu_clr, pu_en, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, res_sel, res_valid};

  function automatic logic [VW-1:0] mk(input logic b, d, c, input logic [15:0] en,
                                        input logic rd, input logic [7:0] ad,
                                        input logic [1:0] sel, input logic v);
    return {b, d, c, en, rd, ad, rd, ad, sel, v};
  endfunction

  task automatic chk(input string tag, input int c, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s c%0d observed %h expected %h", tag, c, got, exp);
    end
  endtask

  // expected per-cycle outputs from c1 onward, derived from the command timeline
  task automatic gen(input int k, input int stall_n, input int abort_c);
    logic [15:0] en;
    q.delete();
    if (k == 0) begin
      q.push_back(mk(1, 1, 0, 16'h0, 0, 8'h0, 2'd0, 0));
      q.push_back('0);
      return;
    end
    q.push_back(mk(1, 0, 1, 16'h0, 0, 8'h0, 2'd0, 0));
    for (int t = 0; t <= k + 2*N - 2; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          en[i*N+j] = (t >= 1 + i + j) && (t <= k + i + j);
      q.push_back(mk(1, 0, 0, en, t < k, (t < k) ? 8'(t) : 8'h0, 2'd0, 0));
    end
    for (int r = 0; r < N; r++)
      repeat ((r == 2) ? 1 + stall_n : 1) q.push_back(mk(1, 0, 0, 16'h0, 0, 8'h0, 2'(r), 1));
    q.push_back(mk(1, 1, 0, 16'h0, 0, 8'h0, 2'd0, 0));
    q.push_back('0);
    if (abort_c > 0) begin
      while (q.size() > abort_c) void'(q.pop_back());
      q.push_back('0);
    end
  endtask

  task automatic run(input string tag, input int k, input int ke, input int stall_n,
                     input int abort_c, input int extra_c, input int reset_c);
    int c = 0;
    gen(ke, stall_n, abort_c);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); res_ready = 1'b1; abort = 1'b0;
    while (q.size() > 0) begin
      @(negedge clk);
      c++;
      chk(tag, c, obs, q.pop_front());
      start = (c == extra_c);
      k_len = KW'(5);
      abort = (c == abort_c);
      res_ready = !(stall_n > 0 && c >= ke + 2*N + 3 && c < ke + 2*N + 3 + stall_n);
      if (c == reset_c) begin
        start = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk({tag, "_rst"}, c, obs, '0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; res_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", 0, obs, '0);
    reset_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort", 0, obs, '0);
    run("T1", 8, 8, 0, 0, 0, 0);
    run("T2", 8, 8, 3, 0, 0, 0);
    run("T3", 0, 0, 0, 0, 0, 0);
    run("T4", 8, 8, 0, 10, 5, 0);
    run("T4b", 8, 8, 0, 0, 0, 0);
    run("T5", 8, 8, 0, 0, 0, 12);
    run("T5b", 8, 8, 0, 0, 0, 0);
    run("T6", 300, 256, 0, 0, 0, 0);
    run("T7", 3, 3, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
